// File: rtl/bram_loader.sv
// Boot loader: streams a data image then an instruction image into two BRAM
// write ports over a valid/ready stream, then releases the core's PC stall.
module bram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  d_count,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_D, LOAD_I, RUN} state_t;

  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  d_len, i_len, word_cnt, seg_len;
  logic                  range_bad, start_ok, accept, beat, last_beat;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Pure state decodes: nothing here depends combinationally on s_valid.
  assign busy      = (state == LOAD_D) || (state == LOAD_I);
  assign s_ready   = busy;
  assign cpu_stall = (state != RUN);
  assign word_addr = ADDR_WIDTH'({word_cnt, 2'b00});

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    range_bad = (d_count > DEPTH_C) || (i_count > DEPTH_C);
    // abort suppresses start everywhere, and start is ignored while loading.
    start_ok  = start && !abort && !busy;
    accept    = start_ok && !range_bad;
    // The abort cycle accepts no beat even though s_ready is still high.
    beat      = busy && s_valid && !abort;
    seg_len   = (state == LOAD_D) ? d_len : i_len;
    last_beat = beat && (word_cnt == seg_len - 1'b1);

    unique case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (d_count != '0)      state_nx = LOAD_D;
          else if (i_count != '0) state_nx = LOAD_I;
          else                    state_nx = RUN;
        end else if (start_ok) begin
          state_nx = IDLE;
        end
      end
      LOAD_D: begin
        if (abort)          state_nx = IDLE;
        else if (last_beat) state_nx = (i_len != '0) ? LOAD_I : RUN;
      end
      LOAD_I: begin
        if (abort)          state_nx = IDLE;
        else if (last_beat) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_w_addr <= '0;
      d_w_dat  <= '0;
      d_w_enb  <= 1'b0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      i_w_enb  <= 1'b0;
      d_len    <= '0;
      i_len    <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      d_w_enb <= beat && (state == LOAD_D);
      i_w_enb <= beat && (state == LOAD_I);
      if (beat && (state == LOAD_D)) begin
        d_w_addr <= word_addr;
        d_w_dat  <= s_data;
      end
      if (beat && (state == LOAD_I)) begin
        i_w_addr <= word_addr;
        i_w_dat  <= s_data;
      end

      if (accept) begin
        d_len    <= d_count;
        i_len    <= i_count;
        word_cnt <= '0;
        err      <= 1'b0;
      end else if (start_ok || (busy && abort)) begin
        err <= 1'b1;
      end

      // The counter restarts at each segment boundary so k is segment-relative.
      if (beat)               word_cnt <= last_beat ? '0 : word_cnt + 1'b1;
      else if (busy && abort) word_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed self-checking bench for bram_loader: nominal, backpressure, reload,
// boundary counts, overflow, abort and asynchronous reset mid-load.
module tb_bram_loader;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [8:0]  d_count = '0;
  logic [8:0]  i_count = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [9:0]  d_w_addr, i_w_addr;
  logic [31:0] d_w_dat, i_w_dat;
  logic        d_w_enb, i_w_enb, cpu_stall, busy, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] img [0:511];
  logic [9:0]  d_addr_q[$], i_addr_q[$];
  logic [31:0] d_dat_q[$], i_dat_q[$];
  time         w_t_q[$];
  logic        both_seen = 1'b0;

  bram_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .d_count(d_count), .i_count(i_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .cpu_stall(cpu_stall), .busy(busy), .err(err)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Write-port recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (d_w_enb) begin
      d_addr_q.push_back(d_w_addr);
      d_dat_q.push_back(d_w_dat);
      w_t_q.push_back($time);
    end
    if (i_w_enb) begin
      i_addr_q.push_back(i_w_addr);
      i_dat_q.push_back(i_w_dat);
      w_t_q.push_back($time);
    end
    if (d_w_enb && i_w_enb) both_seen = 1'b1;
  end

  task automatic clear_logs();
    d_addr_q.delete(); d_dat_q.delete();
    i_addr_q.delete(); i_dat_q.delete();
    w_t_q.delete();
    both_seen = 1'b0;
  endtask

  // Called at a falling edge; returns one cycle later with start deasserted.
  task automatic pulse_start(input int dc, input int ic);
    start = 1'b1; d_count = 9'(dc); i_count = 9'(ic);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents img[first .. first+n-1], one beat per accepted cycle, with gap idle cycles between.
  task automatic stream(input int first, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (!s_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready) begin
        errors++;
        $display("FAIL stream_ready: s_ready=%0b after %0d cycles, required 1", s_ready, guard);
      end
      s_valid = 1'b1;
      s_data  = img[first + k];
      @(negedge clk);
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
    checks++; if ({s_ready, busy, err, d_w_enb, i_w_enb} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {s_ready, busy, err, d_w_enb, i_w_enb}); end
    checks++; if ({d_w_addr, i_w_addr, d_w_dat, i_w_dat} !== '0) begin errors++;
      $display("FAIL reset_bus: got %h want 0", {d_w_addr, i_w_addr, d_w_dat, i_w_dat}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle: stall=%b busy=%b want 1/0", cpu_stall, busy); end
  endtask

  task automatic test_nominal(input int gap, input string tag);
    for (int k = 0; k < 4; k++) img[k] = 32'(k + 1);
    for (int k = 0; k < 5; k++) img[4 + k] = 32'hC0DE_0000 + 32'(k);
    @(negedge clk);
    clear_logs();
    pulse_start(4, 5);
    checks++; if (busy !== 1'b1 || cpu_stall !== 1'b1 || s_ready !== 1'b1) begin errors++;
      $display("FAIL %s_loading: busy=%b stall=%b ready=%b want 1/1/1", tag, busy, cpu_stall, s_ready); end
    stream(0, 8, gap);
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL %s_stall_before_last: got %b want 1", tag, cpu_stall); end
    stream(8, 1, 0);
    checks++; if (cpu_stall !== 1'b0 || i_w_enb !== 1'b1 || i_w_addr !== 10'h010) begin errors++;
      $display("FAIL %s_release: stall=%b i_enb=%b i_addr=%h want 0/1/010", tag, cpu_stall, i_w_enb, i_w_addr); end
    @(negedge clk);
    checks++; if (d_addr_q.size() !== 4 || i_addr_q.size() !== 5) begin errors++;
      $display("FAIL %s_write_count: d=%0d i=%0d want 4/5", tag, d_addr_q.size(), i_addr_q.size()); end
    else begin
      int bad = 0;
      for (int k = 0; k < 4; k++)
        if (d_addr_q[k] !== 10'(4 * k) || d_dat_q[k] !== 32'(k + 1)) bad++;
      for (int k = 0; k < 5; k++)
        if (i_addr_q[k] !== 10'(4 * k) || i_dat_q[k] !== 32'hC0DE_0000 + 32'(k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_write_seq: %0d wrong writes, want 0", tag, bad); end
    end
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL %s_coincident: got 1 want 0", tag); end
    if (w_t_q.size() == 9) begin
      int bad = 0;
      for (int k = 1; k < 9; k++)
        if (w_t_q[k] - w_t_q[k - 1] != time'((gap + 1) * PERIOD)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_write_spacing: %0d gaps wrong, want 0", tag, bad); end
    end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || cpu_stall !== 1'b0) begin errors++;
      $display("FAIL %s_run: busy=%b ready=%b stall=%b want 0/0/0", tag, busy, s_ready, cpu_stall); end
  endtask

  task automatic test_reload();
    img[0] = 32'h1111_0000; img[1] = 32'h1111_0001; img[2] = 32'h2222_0000;
    @(negedge clk);
    clear_logs();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reload_pre_run: stall=%b want 0", cpu_stall); end
    pulse_start(2, 1);
    checks++; if (cpu_stall !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL reload_stall: stall=%b busy=%b want 1/1", cpu_stall, busy); end
    stream(0, 3, 0);
    @(negedge clk);
    checks++; if (d_addr_q.size() !== 2 || i_addr_q.size() !== 1 || cpu_stall !== 1'b0) begin errors++;
      $display("FAIL reload_done: d=%0d i=%0d stall=%b want 2/1/0", d_addr_q.size(), i_addr_q.size(), cpu_stall); end
    else begin
      checks++; if (d_dat_q[1] !== 32'h1111_0001 || i_addr_q[0] !== 10'h000 || i_dat_q[0] !== 32'h2222_0000) begin
        errors++; $display("FAIL reload_data: d1=%h i_addr=%h i0=%h want 11110001/000/22220000",
                          d_dat_q[1], i_addr_q[0], i_dat_q[0]); end
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k < 256; k++) img[k] = 32'h5A00_0000 ^ 32'(k);
    @(negedge clk);
    clear_logs();
    pulse_start(0, 256);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bound_busy: got %b want 1", busy); end
    stream(0, 256, 0);
    checks++; if (i_w_enb !== 1'b1 || i_w_addr !== 10'h3FC || i_w_dat !== 32'h5A00_00FF || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL bound_last: enb=%b addr=%h dat=%h stall=%b want 1/3fc/5a0000ff/0",
                         i_w_enb, i_w_addr, i_w_dat, cpu_stall); end
    @(negedge clk);
    checks++; if (d_addr_q.size() !== 0 || i_addr_q.size() !== 256) begin errors++;
      $display("FAIL bound_count: d=%0d i=%0d want 0/256", d_addr_q.size(), i_addr_q.size()); end
    else begin
      int bad = 0;
      for (int k = 0; k < 256; k++)
        if (i_addr_q[k] !== 10'(4 * k) || i_dat_q[k] !== (32'h5A00_0000 ^ 32'(k))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bound_seq: %0d wrong writes, want 0", bad); end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    clear_logs();
    pulse_start(257, 1);
    checks++; if (err !== 1'b1 || busy !== 1'b0 || cpu_stall !== 1'b1 || s_ready !== 1'b0) begin errors++;
      $display("FAIL ovf_state: err=%b busy=%b stall=%b ready=%b want 1/0/1/0", err, busy, cpu_stall, s_ready); end
    s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    checks++; if (d_addr_q.size() !== 0 || i_addr_q.size() !== 0 || busy !== 1'b0) begin errors++;
      $display("FAIL ovf_writes: d=%0d i=%0d busy=%b want 0/0/0", d_addr_q.size(), i_addr_q.size(), busy); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 7; k++) img[k] = 32'hAB00_0000 + 32'(k);
    @(negedge clk);
    clear_logs();
    pulse_start(3, 4);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b want 0", err); end
    stream(0, 5, 0);
    // abort, a valid beat and a start in the same cycle: abort wins, no beat taken
    abort = 1'b1; start = 1'b1; d_count = 9'd1; i_count = 9'd1;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || err !== 1'b1 || cpu_stall !== 1'b1 || i_w_enb !== 1'b0) begin errors++;
      $display("FAIL abort_state: busy=%b err=%b stall=%b i_enb=%b want 0/1/1/0", busy, err, cpu_stall, i_w_enb); end
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    checks++; if (d_addr_q.size() !== 3 || i_addr_q.size() !== 2 || s_ready !== 1'b0) begin errors++;
      $display("FAIL abort_writes: d=%0d i=%0d ready=%b want 3/2/0", d_addr_q.size(), i_addr_q.size(), s_ready); end
    pulse_start(1, 1);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL abort_restart: err=%b busy=%b want 0/1", err, busy); end
    stream(0, 2, 0);
    checks++; if (cpu_stall !== 1'b0 || i_w_enb !== 1'b1 || i_w_dat !== 32'hAB00_0001) begin errors++;
      $display("FAIL abort_reload: stall=%b i_enb=%b i_dat=%h want 0/1/ab000001", cpu_stall, i_w_enb, i_w_dat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) img[k] = 32'h7700_0000 + 32'(k);
    @(negedge clk);
    pulse_start(8, 1);
    stream(0, 3, 0);
    checks++; if (d_w_enb !== 1'b1 || d_w_addr !== 10'h008) begin errors++;
      $display("FAIL rstmid_inflight: enb=%b addr=%h want 1/008", d_w_enb, d_w_addr); end
    s_valid = 1'b1; s_data = img[3];
    #2 rst = 1'b0;
    #1;
    checks++; if ({d_w_enb, i_w_enb, busy, s_ready, err} !== 5'b0 || cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rstmid_flags: enb/enb/busy/ready/err=%b stall=%b want 00000/1",
               {d_w_enb, i_w_enb, busy, s_ready, err}, cpu_stall); end
    checks++; if ({d_w_addr, d_w_dat, i_w_addr, i_w_dat} !== '0) begin errors++;
      $display("FAIL rstmid_bus: got %h want 0", {d_w_addr, d_w_dat, i_w_addr, i_w_dat}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (d_w_enb !== 1'b0 || busy !== 1'b0 || cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rstmid_idle: enb=%b busy=%b stall=%b want 0/0/1", d_w_enb, busy, cpu_stall); end
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_nominal(1, "backpressure");
    test_reload();
    test_boundary();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
